// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared types for the pipeline hold/flush controller:
// hold level codes, controller states and small helpers.
package pipe_hold_ctrl_pkg;

  localparam int HOLD_W      = 2;
  localparam int INST_ADDR_W = 32;

  typedef logic [HOLD_W-1:0] hold_t;

  localparam hold_t HOLD_NONE  = 2'd0;
  localparam hold_t HOLD_PC    = 2'd1;
  localparam hold_t HOLD_IF_ID = 2'd2;
  localparam hold_t HOLD_ID_EX = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    DIV_WAIT,
    BUS_WAIT,
    IRQ
  } ctrl_state_e;

  function automatic hold_t hold_max(
    input hold_t a,
    input hold_t b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic hold_t state_level(
    input ctrl_state_e s
  );
    case (s)
      IDLE:     return HOLD_NONE;
      BUS_WAIT: return HOLD_IF_ID;
      default:  return HOLD_ID_EX;
    endcase
  endfunction

endpackage

// File: rtl/pipe_hold_ctrl_watchdog.sv
// Fetch-bus stall watchdog: saturating count step,
// timeout strobe and the edge-arm flag for re-entry.
module pipe_hold_ctrl_watchdog #(
  parameter int BUS_TIMEOUT = 256,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wait_i,
  input  logic             bus_stall_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             fire_o,
  output logic             armed_o,
  output logic [CNT_W-1:0] cnt_inc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BUS_TIMEOUT - 1);

  logic armed_d;
  logic armed_q;

  // Timeout strobe, saturating increment and arm flag update.
  always_comb begin
    fire_o    = wait_i & bus_stall_i & (cnt_i == LAST);
    cnt_inc_o = (cnt_i == '1) ? cnt_i : cnt_i + CNT_W'(1);
    armed_d   = armed_q;
    if (!bus_stall_i) begin
      armed_d = 1'b1;
    end else if (fire_o) begin
      armed_d = 1'b0;
    end
  end

  // Arm flag register; a stall that timed out must drop first.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      armed_q <= 1'b1;
    end else begin
      armed_q <= armed_d;
    end
  end

  assign armed_o = armed_q;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush arbiter: merges stall and flush
// requests into one hold level and drives the PC redirect.
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int BUS_TIMEOUT  = 256,
  parameter int CNT_W        = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   jump_req_i,
  input  logic [INST_ADDR_W-1:0] jump_addr_i,
  input  logic                   int_jump_i,
  input  logic [INST_ADDR_W-1:0] int_addr_i,
  input  logic                   irq_hold_i,
  input  logic                   div_start_i,
  input  logic                   div_busy_i,
  input  logic                   bus_stall_i,
  input  logic                   load_use_i,
  output hold_t                  hold_flag_o,
  output logic                   jump_flag_o,
  output logic [INST_ADDR_W-1:0] jump_addr_o,
  output logic                   stall_timeout_o
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  ctrl_state_e      state_q;
  ctrl_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             fire;
  logic             armed;
  logic             from_idle;
  logic             bus_req;
  hold_t            req_lvl;
  hold_t            st_lvl;

  pipe_hold_ctrl_watchdog #(
    .BUS_TIMEOUT (BUS_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wdog (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .wait_i      (state_q == BUS_WAIT),
    .bus_stall_i (bus_stall_i),
    .cnt_i       (cnt_q),
    .fire_o      (fire),
    .armed_o     (armed),
    .cnt_inc_o   (cnt_inc)
  );

  // Next state and shared counter; IRQ exit reuses IDLE entry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    from_idle = (state_q == IDLE) |
                ((state_q == IRQ) & ~irq_hold_i);
    if (from_idle) begin
      state_d = IDLE;
      cnt_d   = '0;
      if (irq_hold_i) begin
        state_d = IRQ;
      end else if (int_jump_i | jump_req_i) begin
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end else if (div_start_i) begin
        state_d = DIV_WAIT;
      end else if (bus_stall_i & armed) begin
        state_d = BUS_WAIT;
      end
    end else begin
      unique case (state_q)
        FLUSH: begin
          if (int_jump_i) begin
            cnt_d = FLUSH_LOAD;
          end else if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DIV_WAIT: begin
          if (!div_busy_i) begin
            state_d = IDLE;
          end
        end
        BUS_WAIT: begin
          if (!bus_stall_i || fire) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        IRQ:     state_d = IRQ;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Hold level merge and redirect mux, forced quiet in reset.
  always_comb begin
    bus_req = bus_stall_i & armed & ~fire;
    req_lvl = HOLD_NONE;
    if (int_jump_i | jump_req_i | irq_hold_i |
        div_start_i | load_use_i) begin
      req_lvl = HOLD_ID_EX;
    end else if (bus_req) begin
      req_lvl = HOLD_IF_ID;
    end
    st_lvl = fire ? HOLD_NONE : state_level(state_q);
    hold_flag_o     = hold_max(st_lvl, req_lvl);
    jump_flag_o     = int_jump_i |
                      (jump_req_i & (state_q == IDLE));
    jump_addr_o     = '0;
    if (int_jump_i) begin
      jump_addr_o = int_addr_i;
    end else if (jump_req_i) begin
      jump_addr_o = jump_addr_i;
    end
    stall_timeout_o = fire;
    if (!rst_n_i) begin
      hold_flag_o     = HOLD_NONE;
      jump_flag_o     = 1'b0;
      jump_addr_o     = '0;
      stall_timeout_o = 1'b0;
    end
  end

endmodule
